// File: rtl/logic_unit_pipe.sv
// Pipelined AND/OR/XOR/NOR unit with zero flag and an elastic valid/ready pipeline of STAGES slots.
// Optional feature: define LOGIC_UNIT_STATS_EN to add stat_clr / op_cnt (delivered-result counter).
module logic_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero
`ifdef LOGIC_UNIT_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [15:0]      op_cnt
`endif
);

  function automatic logic [WIDTH-1:0] logic_op(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [1:0]       sel);
    logic [WIDTH-1:0] r;
    case (sel)
      2'b00:   r = x & y;
      2'b01:   r = x | y;
      2'b10:   r = x ^ y;
      default: r = ~(x | y);
    endcase
    return r;
  endfunction

  logic [STAGES-1:0]            v_q;
  logic [STAGES-1:0]            v_d;
  logic [STAGES-1:0]            en;
  logic [STAGES-1:0][WIDTH-1:0] stage_z;
  logic [STAGES-1:0]            stage_zero;
  logic [WIDTH-1:0]             res_d;
  logic                         res_zero_d;

  assign res_d      = logic_op(a, b, op);
  assign res_zero_d = ~|res_d;

  // A slot may load when it is empty or its occupant moves on this cycle.
  always_comb begin
    en = '0;
    en[STAGES-1] = !v_q[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      en[k] = !v_q[k] | en[k+1];
    end
  end

  always_comb begin
    v_d = v_q;
    if (en[0]) v_d[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      if (en[k]) v_d[k] = v_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] src_z;
    logic             src_zero;
    logic             src_vld;
    logic             ld;
    logic [WIDTH-1:0] d_q;
    logic             zf_q;

    if (k == 0) begin : g_head
      // ---- stage 1: capture the freshly computed result ----
      assign src_z    = res_d;
      assign src_zero = res_zero_d;
      assign src_vld  = in_valid;
    end else begin : g_body
      // ---- stage k+1: forward from the previous slot ----
      assign src_z    = stage_z[k-1];
      assign src_zero = stage_zero[k-1];
      assign src_vld  = v_q[k-1];
    end

    // Data only moves with a valid token, so z holds the last delivered result.
    assign ld = en[k] & src_vld;

    if (k == STAGES - 1) begin : g_last
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d_q  <= '0;
          zf_q <= 1'b0;
        end else if (ld) begin
          d_q  <= src_z;
          zf_q <= src_zero;
        end
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (ld) begin
          d_q  <= src_z;
          zf_q <= src_zero;
        end
      end
    end

    assign stage_z[k]    = d_q;
    assign stage_zero[k] = zf_q;
  end

  assign in_ready  = en[0];
  assign out_valid = v_q[STAGES-1];
  assign z         = stage_z[STAGES-1];
  assign zero      = stage_zero[STAGES-1];

`ifdef LOGIC_UNIT_STATS_EN
  logic [15:0] op_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       op_cnt_q <= '0;
    else if (stat_clr)                op_cnt_q <= '0;
    else if (out_valid && out_ready)  op_cnt_q <= op_cnt_q + 16'd1;
  end

  assign op_cnt = op_cnt_q;
`endif

endmodule
